// File: rtl/postulate_sweep_ctrl.sv
// Sweep controller for the boolean-postulate block: walks xyz 000..111,
// checks each output pair (2k,2k+1) for equality, reports sticky results.
// Ports: i_clk/i_rst (sync, active-high), i_start, i_abort, i_dut_out;
// o_x/o_y/o_z drive the block, o_busy/o_done/o_aborted status,
// o_pass/o_fail_vec/o_first_fail/o_first_valid results.
module postulate_sweep_ctrl #(
  parameter int N_OUT  = 27,
  parameter int SETTLE = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [N_OUT-1:0]   i_dut_out,
  output logic               o_x,
  output logic               o_y,
  output logic               o_z,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_aborted,
  output logic               o_pass,
  output logic [N_OUT/2-1:0] o_fail_vec,
  output logic [2:0]         o_first_fail,
  output logic               o_first_valid
);

  localparam int N_PAIRS = N_OUT / 2;
  localparam logic [3:0] SLOAD = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t             state, state_n;
  logic [2:0]         comb, comb_n;
  logic [3:0]         scnt, scnt_n;
  logic [2:0]         xyz, xyz_n;
  logic [N_PAIRS-1:0] fail, fail_n;
  logic [2:0]         first, first_n;
  logic               firstv, firstv_n;
  logic               pass, pass_n;
  logic               abt, abt_n;
  logic [N_PAIRS-1:0] mm;

  // An odd trailing output bit has no partner and is never checked.
  logic unused_dut;
  assign unused_dut = ^i_dut_out;

  always_comb begin
    mm = '0;
    for (int k = 0; k < N_PAIRS; k++) begin
      mm[k] = i_dut_out[2*k] ^ i_dut_out[2*k+1];
    end
  end

  always_comb begin
    state_n  = state;
    comb_n   = comb;
    scnt_n   = scnt;
    xyz_n    = xyz;
    fail_n   = fail;
    first_n  = first;
    firstv_n = firstv;
    pass_n   = pass;
    abt_n    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_start) begin
          fail_n   = '0;
          first_n  = '0;
          firstv_n = 1'b0;
          pass_n   = 1'b0;
          comb_n   = '0;
          xyz_n    = '0;
          scnt_n   = SLOAD;
          state_n  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (i_abort) begin
          abt_n   = 1'b1;
          xyz_n   = '0;
          state_n = S_IDLE;
        end else if (scnt == '0) begin
          state_n = S_SAMPLE;
        end else begin
          scnt_n = scnt - 4'd1;
        end
      end
      S_SAMPLE: begin
        if (i_abort) begin
          abt_n   = 1'b1;
          xyz_n   = '0;
          state_n = S_IDLE;
        end else begin
          fail_n = fail | mm;
          if ((|mm) && !firstv) begin
            first_n  = comb;
            firstv_n = 1'b1;
          end
          if (comb == 3'd7) begin
            // Pass must already be valid in the DONE cycle.
            pass_n  = ~|(fail | mm);
            xyz_n   = '0;
            state_n = S_DONE;
          end else begin
            comb_n  = comb + 3'd1;
            xyz_n   = comb + 3'd1;
            scnt_n  = SLOAD;
            state_n = S_SETTLE;
          end
        end
      end
      S_DONE: begin
        xyz_n   = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_IDLE;
      comb   <= '0;
      scnt   <= '0;
      xyz    <= '0;
      fail   <= '0;
      first  <= '0;
      firstv <= 1'b0;
      pass   <= 1'b0;
      abt    <= 1'b0;
    end else begin
      state  <= state_n;
      comb   <= comb_n;
      scnt   <= scnt_n;
      xyz    <= xyz_n;
      fail   <= fail_n;
      first  <= first_n;
      firstv <= firstv_n;
      pass   <= pass_n;
      abt    <= abt_n;
    end
  end

  assign {o_x, o_y, o_z} = xyz;
  assign o_busy          = (state == S_SETTLE) || (state == S_SAMPLE);
  assign o_done          = (state == S_DONE);
  assign o_aborted       = abt;
  assign o_pass          = pass;
  assign o_fail_vec      = fail;
  assign o_first_fail    = first;
  assign o_first_valid   = firstv;

endmodule

// File: tb/tb_postulate_sweep_ctrl.sv
// Scoreboard bench for postulate_sweep_ctrl: random postulate tables and
// injected pair faults, expected events queued, checked by a monitor.
module tb_postulate_sweep_ctrl;

  localparam int NO = 27;
  localparam int NP = 13;
  localparam int S0 = 2;
  localparam int S1 = 1;
  localparam int P0 = S0 + 1;
  localparam int P1 = S1 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, st0, ab0, st1, ab1;
  logic [NO-1:0] dout0, dout1;
  logic x0, y0, z0, busy0, done0, abt0, pass0, fvl0;
  logic x1, y1, z1, busy1, done1, abt1, pass1, fvl1;
  logic [NP-1:0] fv0, fv1;
  logic [2:0] ff0, ff1;

  postulate_sweep_ctrl #(.N_OUT(NO), .SETTLE(S0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(st0), .i_abort(ab0),
    .i_dut_out(dout0), .o_x(x0), .o_y(y0), .o_z(z0),
    .o_busy(busy0), .o_done(done0), .o_aborted(abt0), .o_pass(pass0),
    .o_fail_vec(fv0), .o_first_fail(ff0), .o_first_valid(fvl0)
  );

  postulate_sweep_ctrl #(.N_OUT(NO), .SETTLE(S1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(st1), .i_abort(ab1),
    .i_dut_out(dout1), .o_x(x1), .o_y(y1), .o_z(z1),
    .o_busy(busy1), .o_done(done1), .o_aborted(abt1), .o_pass(pass1),
    .o_fail_vec(fv1), .o_first_fail(ff1), .o_first_valid(fvl1)
  );

  typedef struct {
    logic          ab;
    int            cyc;
    logic          pass;
    logic [NP-1:0] fv;
    logic [2:0]    ff;
    logic          fvl;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0]    tt [0:NP];
  logic [NP-1:0] fmask [0:7];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [NO-1:0] model_out(input logic [2:0] c);
    logic [NO-1:0] o;
    o = '0;
    for (int k = 0; k < NP; k++) begin
      o[2*k]   = tt[k][c];
      o[2*k+1] = tt[k][c] ^ fmask[c][k];
    end
    o[NO-1] = tt[NP][c];
    return o;
  endfunction

  // Inputs only change at posedge, sampling happens a posedge later.
  always @(negedge clk) begin
    dout0 = model_out({x0, y0, z0});
    dout1 = model_out({x1, y1, z1});
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model(input int n, output logic [NP-1:0] fv,
                       output logic [2:0] ff, output logic fvl);
    fv = '0;
    ff = '0;
    fvl = 1'b0;
    for (int c = 0; c < n; c++) begin
      fv |= fmask[c];
      if (fmask[c] != '0 && !fvl) begin
        ff = 3'(c);
        fvl = 1'b1;
      end
    end
  endtask

  task automatic mon(input int inst, input logic d, input logic a,
                     input logic p, input logic [NP-1:0] fv,
                     input logic [2:0] ff, input logic fvl);
    exp_t e;
    if (!(d || a)) return;
    if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event inst%0d: done=%b aborted=%b at cyc %0d",
               inst, d, a, cyc);
      return;
    end
    e = (inst == 0) ? q0.pop_front() : q1.pop_front();
    chk($sformatf("evt_kind%0d", inst), {d, a}, {~e.ab, e.ab});
    chk($sformatf("evt_cycle%0d", inst), cyc, e.cyc);
    chk($sformatf("pass%0d", inst), p, e.pass);
    chk($sformatf("fail_vec%0d", inst), fv, e.fv);
    chk($sformatf("first_fail%0d", inst), ff, e.ff);
    chk($sformatf("first_valid%0d", inst), fvl, e.fvl);
  endtask

  always @(negedge clk) begin
    mon(0, done0, abt0, pass0, fv0, ff0, fvl0);
    mon(1, done1, abt1, pass1, fv1, ff1, fvl1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_masks;
    for (int c = 0; c < 8; c++) fmask[c] = '0;
  endtask

  task automatic rand_env(input int pct);
    for (int k = 0; k <= NP; k++) tt[k] = 8'($urandom);
    for (int c = 0; c < 8; c++)
      fmask[c] = ($urandom_range(0, 99) < pct) ? NP'($urandom) : '0;
  endtask

  task automatic sweep0(input int abort_at, input int extra_at);
    exp_t e;
    int t0, endm, bad;
    logic [NP-1:0] fv;
    logic [2:0] ff;
    logic fvl;
    st0 = 1'b1;
    tick();
    t0 = cyc;
    st0 = 1'b0;
    endm = (abort_at > 0) ? abort_at : 8 * P0;
    model((abort_at > 0) ? (abort_at - 1) / P0 : 8, fv, ff, fvl);
    e.ab = (abort_at > 0);
    e.cyc = t0 + endm;
    e.pass = (abort_at == 0) && (fv == '0);
    e.fv = fv;
    e.ff = ff;
    e.fvl = fvl;
    q0.push_back(e);
    bad = 0;
    if ({x0, y0, z0} !== 3'd0 || busy0 !== 1'b1) bad++;
    for (int m = 1; m <= endm; m++) begin
      ab0 = (m == abort_at);
      st0 = (m == extra_at);
      tick();
      if (m < endm) begin
        if ({x0, y0, z0} !== 3'(m / P0) || busy0 !== 1'b1) bad++;
      end else if ({x0, y0, z0} !== 3'd0 || busy0 !== 1'b0) begin
        bad++;
      end
    end
    ab0 = 1'b0;
    st0 = 1'b0;
    tick();
    chk("sweep_seq", bad, 0);
    chk("drain0", q0.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    int t0, ab, ex;
    logic [NP-1:0] fv;
    logic [2:0] ff;
    logic fvl;

    rst = 1'b1;
    st0 = 1'b0; ab0 = 1'b0; st1 = 1'b0; ab1 = 1'b0;
    for (int k = 0; k <= NP; k++) tt[k] = '0;
    clear_masks();
    tick();
    tick();
    chk("rst_xyz", {x0, y0, z0}, 3'd0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_aborted", abt0, 1'b0);
    chk("rst_pass", pass0, 1'b0);
    chk("rst_fail_vec", fv0, '0);
    chk("rst_first", {fvl0, ff0}, 4'd0);
    rst = 1'b0;
    tick();

    // All pairs equal.
    rand_env(0);
    sweep0(0, 0);
    chk("clean_pass", pass0, 1'b1);
    chk("clean_fv", fv0, '0);
    chk("clean_fvl", fvl0, 1'b0);

    // Pair 3 broken only at 101.
    clear_masks();
    fmask[5] = 13'h0008;
    sweep0(0, 0);
    chk("p3_fv", fv0, 13'h0008);
    chk("p3_ff", ff0, 3'b101);
    chk("p3_fvl", fvl0, 1'b1);
    chk("p3_pass", pass0, 1'b0);

    // Pair 0 at 010 and pair 12 at 110.
    clear_masks();
    fmask[2] = 13'h0001;
    fmask[6] = 13'h1000;
    sweep0(0, 0);
    chk("p0p12_fv", fv0, 13'h1001);
    chk("p0p12_ff", ff0, 3'b010);

    // Abort during the 011 phase.
    rand_env(60);
    sweep0(10, 0);
    chk("abort_pass", pass0, 1'b0);

    // Abort while idle is ignored.
    ab0 = 1'b1;
    tick();
    ab0 = 1'b0;
    chk("idle_abort", {abt0, busy0}, 2'b00);

    // Reset together with start mid-sweep.
    clear_masks();
    fmask[0] = 13'h0010;
    st0 = 1'b1;
    tick();
    st0 = 1'b0;
    repeat (6) tick();
    chk("pre_rst_fv", fv0, 13'h0010);
    rst = 1'b1;
    st0 = 1'b1;
    tick();
    chk("mid_rst_state", {x0, y0, z0, busy0, done0, abt0, pass0}, 7'd0);
    chk("mid_rst_res", {fv0, ff0, fvl0}, '0);
    rst = 1'b0;
    st0 = 1'b0;
    tick();
    rand_env(50);
    sweep0(0, 0);

    // Randomized sweeps with aborts and ignored mid-sweep starts.
    for (int i = 0; i < 20; i++) begin
      rand_env(35);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8 * P0) : 0;
      ex = 0;
      if ($urandom_range(0, 1) == 1) begin
        if (ab == 0) ex = $urandom_range(1, 8 * P0 - 1);
        else if (ab > 2) ex = $urandom_range(1, ab - 1);
      end
      sweep0(ab, ex);
      repeat ($urandom_range(0, 2)) tick();
    end

    // Held start with SETTLE=1: DONE-cycle start ignored, next IDLE accepts.
    rand_env(50);
    model(8, fv, ff, fvl);
    st1 = 1'b1;
    tick();
    t0 = cyc;
    e.ab = 1'b0;
    e.pass = (fv == '0);
    e.fv = fv;
    e.ff = ff;
    e.fvl = fvl;
    e.cyc = t0 + 8 * P1;
    q1.push_back(e);
    e.cyc = t0 + 8 * P1 + 2 + 8 * P1;
    q1.push_back(e);
    repeat (8 * P1) tick();
    tick();
    chk("held_idle_gap", busy1, 1'b0);
    chk("held_pass_hold", pass1, fv == '0);
    tick();
    chk("held_restart", busy1, 1'b1);
    st1 = 1'b0;
    for (int w = 0; w < 40 && q1.size() != 0; w++) tick();
    tick();
    chk("drain1", q1.size(), 0);
    chk("inst0_quiet", busy0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
